i2s_capture_ctrl: RTL and testbench
===================================

Name: i2s_capture_ctrl

Overview:
- Sequences a capture session on the I2S MEMS receiver: powers up the receiver clocks, discards settling frames, then forwards a bounded or continuous run of stereo frames to a downstream sample sink.
- Sink interface is a 24-bit valid/ready stream.
- Sits between the I2S receiver's per-frame L/R outputs and the storage/DSP path; started and stopped by the key logic or a host.

Parameters:
- WARMUP_FRAMES, 16, frames discarded after mic_en rises (MEMS startup settling)
- FCNT_W, 16, width of cfg_frames and frame_cnt

Ports:
- clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start request
- stop  in  1  one-cycle stop request
- cfg_frames  in  FCNT_W  frames to capture; 0 = continuous until stop; latched on accepted start
- smp_valid  in  1  one-cycle pulse from receiver: smp_l/smp_r hold a complete new frame
- smp_l  in  24  left sample
- smp_r  in  24  right sample
- mic_en  out  1  enables receiver SCK/WS generation
- wr_valid  out  1  output word valid
- wr_data  out  24  output word
- wr_chan  out  1  0 = left, 1 = right
- wr_ready  in  1  sink accepts word when wr_valid & wr_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE from DRAIN
- overflow  out  1  sticky: a frame was dropped; cleared on accepted start
- frame_cnt  out  FCNT_W  frames accepted this session; cleared on accepted start; saturates at all-ones

Behaviour:
- Clock and reset: single clock clk; Reset_n asynchronous, active-low.
- Reset values: state IDLE; all outputs 0 (mic_en, wr_valid, wr_data, wr_chan, busy, done, overflow, frame_cnt). Reset mid-session aborts immediately; no done pulse.
- IDLE:
  - start=1 -> WARMUP next cycle; latch cfg_frames; clear frame_cnt, overflow and warmup counter.
  - start and stop in the same cycle -> stop wins; remain IDLE.
  - stop alone is ignored.
- WARMUP:
  - mic_en=1, busy=1.
  - Count smp_valid pulses and discard them.
  - After the WARMUP_FRAMES-th pulse -> CAPTURE; that pulse is also discarded.
  - WARMUP_FRAMES=0 -> go straight to CAPTURE on the first clock after start.
  - stop -> IDLE directly, with a done pulse; mic_en drops the same cycle as the state change.
- CAPTURE:
  - smp_valid with holding buffer empty: latch smp_l/smp_r into the buffer; increment frame_cnt.
  - The next cycle wr_valid=1, wr_chan=0, wr_data=L. One-cycle latency from smp_valid to wr_valid.
  - On the L handshake, the following cycle presents R (wr_chan=1). The buffer empties on the R handshake.
  - wr_data and wr_chan hold stable while wr_valid & !wr_ready. wr_valid never drops without a handshake.
  - smp_valid while the buffer is still occupied: drop the new frame; set overflow; frame_cnt unchanged.
  - A smp_valid in the same cycle as the R handshake is accepted; the buffer frees and reloads in that cycle.
  - Frame limit: cfg_frames!=0 and frame_cnt reaches cfg_frames on an accept -> DRAIN. Later smp_valid pulses are ignored and do not set overflow.
  - stop -> DRAIN; a smp_valid in the same cycle as stop is ignored.
- DRAIN:
  - mic_en stays 1; no new frames accepted.
  - Finish any pending L/R words.
  - When the buffer is empty -> IDLE, done=1 for one cycle, mic_en=0, busy=0.
  - An empty buffer on entry gives IDLE on the next cycle.
- Word order: always L then R per frame; no partial frames emitted.
- start while busy is ignored.

Optional Feature:
- Macro I2S_CAP_MONO_EN.
- Defined: only the left word is emitted per frame (wr_chan always 0). The buffer empties on the L handshake; smp_r is ignored.
- Undefined: stereo L/R interleave as above.

Test Plan:
- WARMUP_FRAMES=2, cfg_frames=3, wr_ready=1, frames (L,R)=(0x000001,0x800001)..(0x000005,0x800005):
  - Frames 1-2 discarded; output 0x000003,0x800003,0x000004,0x800004,0x000005,0x800005.
  - Then done pulse; frame_cnt=3; overflow=0; mic_en=0.
- cfg_frames=0, wr_ready=1, stop after 4 captured frames -> exactly 8 words; done one cycle after the last R handshake; frame_cnt=4.
- Hold wr_ready=0 for 40 cycles across two smp_valid pulses:
  - Second frame dropped; overflow=1; frame_cnt=1.
  - wr_data stays the first L value until ready rises.
- smp_valid coincident with the R handshake -> new frame accepted; next L presented the following cycle; overflow stays 0.
- start and stop asserted together in IDLE -> stays IDLE, mic_en=0.
- Reset_n low mid-CAPTURE with wr_valid=1 -> all outputs 0 immediately; no done pulse.
- I2S_CAP_MONO_EN build: 2 frames -> 2 words, both wr_chan=0.

Source files
------------

// File: rtl/i2s_capture_ctrl.sv
// Capture-session sequencer between the I2S MEMS receiver and a 24-bit sample sink.
// Latency: one cycle from an accepted smp_valid to wr_valid (left word first).
// Backpressure: a one-frame holding buffer. A frame that arrives while the buffer is occupied is dropped and flagged in overflow.
//
// Parameters: WARMUP_FRAMES (settling frames discarded after mic_en rises), FCNT_W (frame counter width)
// Ports: clk, Reset_n (async active-low); start/stop requests; cfg_frames (0 = continuous);
//        smp_valid/smp_l/smp_r from the receiver; mic_en to the receiver;
//        wr_valid/wr_data/wr_chan/wr_ready sink stream; busy, done, overflow, frame_cnt status.
// Optional build macro: I2S_CAP_MONO_EN emits only the left word of each frame.
module i2s_capture_ctrl #(
    parameter int WARMUP_FRAMES = 16,
    parameter int FCNT_W        = 16
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [FCNT_W-1:0] cfg_frames,
    input  logic              smp_valid,
    input  logic [23:0]       smp_l,
    input  logic [23:0]       smp_r,
    output logic              mic_en,
    output logic              wr_valid,
    output logic [23:0]       wr_data,
    output logic              wr_chan,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // The counter only has to reach WARMUP_FRAMES-1; the pulse after that ends warmup.
    localparam int WC_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   warm_cnt_q;
    logic [FCNT_W-1:0] limit_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [23:0]       buf_l_q, buf_r_q;
    logic              buf_full_q;
    logic              phase_q;      // 0: left word pending, 1: right word pending
    logic              done_q;
    logic              overflow_q;

    logic              hs;
    logic              release_w;
    logic              start_ok;
    logic              warm_last;
    logic              accept;
    logic              drop;
    logic [FCNT_W-1:0] cnt_inc;

    assign hs = buf_full_q & wr_ready;

    // The buffer is freed by the handshake of the last word of the frame.
`ifdef I2S_CAP_MONO_EN
    assign release_w = hs;
`else
    assign release_w = hs & phase_q;
`endif

    // stop has priority over start in IDLE.
    assign start_ok  = (state_q == S_IDLE) & start & ~stop;
    assign warm_last = (WARMUP_FRAMES == 0) ||
                       (smp_valid && (warm_cnt_q == WC_W'(WARMUP_FRAMES - 1)));

    // A frame landing on the final handshake can reuse the buffer in the same cycle.
    assign accept = (state_q == S_CAPTURE) & smp_valid & ~stop & (~buf_full_q | release_w);
    assign drop   = (state_q == S_CAPTURE) & smp_valid & ~stop & buf_full_q & ~release_w;

    assign cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + FCNT_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (stop)           state_d = S_IDLE;
                else if (warm_last) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (stop)
                    state_d = S_DRAIN;
                else if (accept && (limit_q != '0) && (cnt_inc == limit_q))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave as soon as the buffer is empty after this cycle.
                if (!buf_full_q || release_w) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= '0;
            limit_q     <= '0;
            frame_cnt_q <= '0;
            buf_l_q     <= '0;
            buf_r_q     <= '0;
            buf_full_q  <= 1'b0;
            phase_q     <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);

            if (start_ok) begin
                limit_q     <= cfg_frames;
                frame_cnt_q <= '0;
                overflow_q  <= 1'b0;
                warm_cnt_q  <= '0;
            end

            if ((state_q == S_WARMUP) && smp_valid)
                warm_cnt_q <= warm_cnt_q + WC_W'(1);

            if (accept) frame_cnt_q <= cnt_inc;
            if (drop)   overflow_q  <= 1'b1;

            if (accept) begin
                buf_l_q    <= smp_l;
                buf_r_q    <= smp_r;
                buf_full_q <= 1'b1;
                phase_q    <= 1'b0;
            end else if (release_w) begin
                buf_full_q <= 1'b0;
                phase_q    <= 1'b0;
            end else if (hs) begin
                phase_q    <= 1'b1;
            end
        end
    end

    assign mic_en    = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
    assign wr_valid  = buf_full_q;
    assign wr_chan   = phase_q;
    assign wr_data   = phase_q ? buf_r_q : buf_l_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
module tb_i2s_capture_ctrl;

    localparam int WF = 2;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [FW-1:0] cfg_frames = '0;
    logic          smp_valid = 1'b0;
    logic [23:0]   smp_l = '0;
    logic [23:0]   smp_r = '0;
    logic          wr_ready = 1'b0;
    logic          mic_en, wr_valid, wr_chan, busy, done, overflow;
    logic [23:0]   wr_data;
    logic [FW-1:0] frame_cnt;

    i2s_capture_ctrl #(.WARMUP_FRAMES(WF), .FCNT_W(FW)) dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .stop(stop),
        .cfg_frames(cfg_frames), .smp_valid(smp_valid), .smp_l(smp_l), .smp_r(smp_r),
        .mic_en(mic_en), .wr_valid(wr_valid), .wr_data(wr_data), .wr_chan(wr_chan),
        .wr_ready(wr_ready), .busy(busy), .done(done), .overflow(overflow),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Session-level reference: phase 0 idle, 1 warmup, 2 capture, 3 drain.
    // m_q holds the words of the frame still owed to the sink as {chan, data}.
    int          m_phase, m_warm, m_limit, m_cnt;
    bit          m_ovf, m_done;
    logic [24:0] m_q[$];

    function automatic void m_reset();
        m_phase = 0; m_warm = 0; m_limit = 0; m_cnt = 0;
        m_ovf = 1'b0; m_done = 1'b0;
        m_q.delete();
    endfunction

    function automatic void m_step();
        bit hs;
        hs = (m_q.size() != 0) && wr_ready;
        m_done = 1'b0;
        case (m_phase)
            0: if (start && !stop) begin
                m_phase = 1; m_limit = int'(cfg_frames); m_cnt = 0; m_ovf = 1'b0; m_warm = 0;
            end
            1: if (stop) begin
                m_phase = 0; m_done = 1'b1;
            end else if (WF == 0) begin
                m_phase = 2;
            end else if (smp_valid) begin
                m_warm++;
                if (m_warm == WF) m_phase = 2;
            end
            2: begin
                if (hs) void'(m_q.pop_front());
                if (stop) m_phase = 3;
                else if (smp_valid) begin
                    if (m_q.size() == 0) begin
                        m_q.push_back({1'b0, smp_l});
`ifndef I2S_CAP_MONO_EN
                        m_q.push_back({1'b1, smp_r});
`endif
                        if (m_cnt < (1 << FW) - 1) m_cnt++;
                        if (m_limit != 0 && m_cnt == m_limit) m_phase = 3;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            default: begin
                if (hs) void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_phase = 0; m_done = 1'b1;
                end
            end
        endcase
    endfunction

    logic [23:0] log_d[$];
    logic        log_c[$];
    int          last_hs_cyc = 0;
    int          done_cyc = 0;
    int          done_pulses = 0;

    initial m_reset();

    always @(negedge clk) begin
        if (!Reset_n) begin
            m_reset();
            chk("rst_wr_data", wr_data, 0);
            chk("rst_wr_chan", wr_chan, 0);
        end
        chk("mic_en", mic_en, m_phase != 0);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("wr_valid", wr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("wr_chan", wr_chan, m_q[0][24]);
            chk("wr_data", wr_data, m_q[0][23:0]);
        end
        if (Reset_n && wr_valid && wr_ready) begin
            log_d.push_back(wr_data);
            log_c.push_back(wr_chan);
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cyc = cyc;
            done_pulses++;
        end
        if (Reset_n) m_step();
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start(input int cfg);
        cfg_frames = FW'(cfg);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        smp_l = l; smp_r = r; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int dbase;
        logic [31:0] rv;

        tick(3);
        chk("reset_mic_en", mic_en, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        Reset_n = 1'b1;
        tick(2);

        // Bounded session: 2 warmup frames discarded, 3 frames forwarded.
        wr_ready = 1'b1;
        base = log_d.size();
        dbase = done_pulses;
        pulse_start(3);
        for (int k = 1; k <= 5; k++) begin
            frame(24'(k), 24'h800000 | 24'(k));
            tick(3);
        end
        tick(5);
`ifndef I2S_CAP_MONO_EN
        chk("t1_words", log_d.size() - base, 6);
        if (log_d.size() - base == 6) begin
            for (int k = 0; k < 3; k++) begin
                chk("t1_L_data", log_d[base + 2*k], 32'(k + 3));
                chk("t1_L_chan", log_c[base + 2*k], 0);
                chk("t1_R_data", log_d[base + 2*k + 1], 32'h800000 | 32'(k + 3));
                chk("t1_R_chan", log_c[base + 2*k + 1], 1);
            end
        end
`else
        chk("t1_words", log_d.size() - base, 3);
        if (log_d.size() - base == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t1_mono_data", log_d[base + k], 32'(k + 3));
                chk("t1_mono_chan", log_c[base + k], 0);
            end
        end
`endif
        chk("t1_done_pulses", done_pulses - dbase, 1);
        chk("t1_frame_cnt", frame_cnt, 3);
        chk("t1_overflow", overflow, 0);
        chk("t1_mic_en", mic_en, 0);

        // Continuous session stopped after 4 captured frames.
        base = log_d.size();
        dbase = done_pulses;
        pulse_start(0);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h0, 24'h0); tick(1);
        for (int k = 0; k < 4; k++) begin
            frame(24'h100 + 24'(k), 24'h200 + 24'(k));
            if (k < 3) tick(3);
        end
        pulse_stop();
        tick(6);
`ifndef I2S_CAP_MONO_EN
        chk("t2_words", log_d.size() - base, 8);
        chk("t2_done_after_last_hs", done_cyc - last_hs_cyc, 1);
`else
        chk("t2_words", log_d.size() - base, 4);
`endif
        chk("t2_done_pulses", done_pulses - dbase, 1);
        chk("t2_frame_cnt", frame_cnt, 4);

        // Sink stalled across two frames: second one dropped.
        wr_ready = 1'b0;
        pulse_start(0);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h123456, 24'hABCDEF);
        tick(10);
        frame(24'h111111, 24'h222222);
        tick(27);
        chk("t3_stall_valid", wr_valid, 1);
        chk("t3_stall_data", wr_data, 32'h123456);
        chk("t3_overflow", overflow, 1);
        chk("t3_frame_cnt", frame_cnt, 1);
        wr_ready = 1'b1;
        tick(3);
        pulse_stop();
        tick(3);

        // New frame arriving on the right-word handshake is accepted.
        pulse_start(0);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h0A0A0A, 24'h0B0B0B);
`ifndef I2S_CAP_MONO_EN
        tick(1);
`endif
        frame(24'h0C0C0C, 24'h0D0D0D);
        chk("t4_valid", wr_valid, 1);
        chk("t4_chan", wr_chan, 0);
        chk("t4_data", wr_data, 32'h0C0C0C);
        chk("t4_overflow", overflow, 0);
        chk("t4_frame_cnt", frame_cnt, 2);
        tick(3);
        pulse_stop();
        tick(3);

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t5_mic_en", mic_en, 0);
        chk("t5_busy", busy, 0);
        tick(2);
        chk("t5_mic_en_later", mic_en, 0);

        // Reset while a word is waiting in CAPTURE.
        wr_ready = 1'b0;
        dbase = done_pulses;
        pulse_start(0);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h0, 24'h0); tick(1);
        frame(24'h777777, 24'h888888);
        chk("t6_pre_valid", wr_valid, 1);
        Reset_n = 1'b0;
        #1;
        chk("t6_wr_valid", wr_valid, 0);
        chk("t6_wr_data", wr_data, 0);
        chk("t6_mic_en", mic_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_frame_cnt", frame_cnt, 0);
        tick(2);
        Reset_n = 1'b1;
        tick(2);
        chk("t6_no_done", done_pulses - dbase, 0);

        // Randomized sessions against the reference model.
        for (int s = 0; s < 8; s++) begin
            pulse_start(int'($urandom_range(0, 4)));
            for (int c = 0; c < 150; c++) begin
                rv = $urandom;
                smp_l = rv[23:0];
                rv = $urandom;
                smp_r = rv[23:0];
                smp_valid = ($urandom_range(0, 2) == 0);
                wr_ready = ($urandom_range(0, 3) != 0);
                stop = ($urandom_range(0, 79) == 0);
                start = ($urandom_range(0, 39) == 0);
                cfg_frames = FW'($urandom_range(0, 5));
                tick();
            end
            smp_valid = 1'b0; start = 1'b0;
            wr_ready = 1'b1;
            pulse_stop();
            tick(8);
            chk("rand_idle", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
